vh_parity_decoder: RTL and testbench
====================================

Name: vh_parity_decoder

Overview:
- Streaming receive-side decoder for the 24-bit vertical/horizontal parity code produced by the team's 16-bit coder.
- Each 24-bit codeword arrives on a valid/ready handshake and goes through a 2-stage pipeline.
- Single-bit errors are corrected; double and other multi-bit errors are flagged.
- Delivers the 16-bit data word plus a status code. Sits between the channel (bit_flip injection point) and the consumer.

Parameters:
- CNT_W, 16, width of the saturating error-statistics counters (range 4..32).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_code  in  24  codeword. [15:0] data d[r*4+c], 4x4 row-major; [19:16] even row parity r0..r3; [23:20] even column parity c0..c3.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  decoder accepts in_code this cycle.
- out_data  out  16  decoded (corrected) data.
- out_status  out  2  00 clean; 01 data bit corrected; 10 parity bit error (data intact); 11 uncorrectable.
- out_valid  out  1  out_data/out_status valid.
- out_ready  in  1  consumer accepts output.
- stat_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of delivered words with status 01 or 10.
- uncorr_cnt  out  CNT_W  count of delivered words with status 11.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valids 0, out_data 0, out_status 00, out_valid 0, counters 0. in_ready is 1 after reset.
- A word in flight during reset is discarded; no output appears after rst_n deasserts.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (global stall). Input transfer = in_valid && in_ready.
- Stage 1 (on en): register the codeword, row syndrome and column syndrome, plus s1_valid <= transfer.
  - rs[r] = r_r ^ XOR of d[r*4+0..3].
  - cs[c] = c_c ^ XOR of d[0..3*4+c].
- Stage 2 (on en): classify, correct, and register outputs; out_valid <= s1_valid.
  - rs==0 and cs==0: status 00, data unchanged.
  - popcount(rs)==1 and popcount(cs)==1: flip d[r*4+c]; status 01.
  - popcount(rs)+popcount(cs)==1: status 10, data unchanged.
  - Any other pattern: status 11, raw data passed through uncorrected.
- Latency: 2 cycles from input transfer to out_valid when out_ready is held high. Throughput 1 word per cycle.
- Backpressure: when out_valid && !out_ready, every stage holds and out_data/out_status stay stable. in_ready drops in the same cycle.
- Outputs change only on en. Data is never dropped or duplicated.
- Counters increment only on output transfer (out_valid && out_ready), according to out_status.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - stat_clr has priority over an increment in the same cycle; the result is 0.

Optional Feature:
- Macro VH_DEC_STATS_EN.
- Defined: corr_cnt/uncorr_cnt are implemented as described above.
- Undefined: counter logic is omitted; corr_cnt and uncorr_cnt are tied to 0 and stat_clr is ignored. Decode path timing and function are unchanged.

Test Plan:
- Clean word: in_code 0x110001 (data 0x0001), out_ready=1 -> 2 cycles later out_data 0x0001, status 00, counters unchanged.
- Data error: in_code 0x000020 (bit d5 flipped from 0x000000; rs=0010, cs=0010) -> out_data 0x0000, status 01, corr_cnt 1.
- Parity error: in_code 0x100001 (r0 flipped from 0x110001) -> out_data 0x0001, status 10, corr_cnt increments.
- Double error: in_code 0x000021 (rs=0011, cs=0011) -> out_data 0x0021, status 11, uncorr_cnt 1.
- Backpressure: stream 4 words with out_ready held low 3 cycles after the first output.
  - out_data stays stable and in_ready stays 0 during the stall.
  - All 4 words are delivered in order with no loss.
- Reset and stats: assert rst_n low with 2 words in flight -> out_valid 0 immediately; no output after release.
  - With VH_DEC_STATS_EN and CNT_W=4: 16 corrected words -> corr_cnt 15 (saturated).
  - stat_clr pulsed together with a delivery -> 0.

Source files
------------

// File: rtl/vh_parity_decoder.sv
`default_nettype none
// ============================================================================
// Module  : vh_parity_decoder
// Brief   : 2-stage correcting decoder for the 24-bit V/H parity code.
//           Define VH_DEC_STATS_EN to build the corrected/uncorrectable counters.
// Rev     : 1.0  initial release
// ============================================================================
module vh_parity_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [23:0]      in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      out_data,
  output logic [1:0]       out_status,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam logic [1:0] c_ST_CLEAN  = 2'b00;
  localparam logic [1:0] c_ST_CORR   = 2'b01;
  localparam logic [1:0] c_ST_PARITY = 2'b10;
  localparam logic [1:0] c_ST_UNCORR = 2'b11;

  logic        w_en;
  logic [3:0]  w_rs;
  logic [3:0]  w_cs;
  logic        r_s1_valid;
  logic [15:0] r_s1_data;
  logic [3:0]  r_s1_rs;
  logic [3:0]  r_s1_cs;
  logic [2:0]  w_rs_pop;
  logic [2:0]  w_cs_pop;
  logic [1:0]  w_row;
  logic [1:0]  w_col;
  logic [15:0] w_dec_data;
  logic [1:0]  w_dec_status;

  // Global stall: the whole pipeline advances only when the output slot frees.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  always_comb begin
    w_rs = '0;
    w_cs = '0;
    for (int r = 0; r < 4; r++) begin
      w_rs[r] = in_code[16+r] ^ in_code[r*4] ^ in_code[r*4+1] ^ in_code[r*4+2] ^ in_code[r*4+3];
    end
    for (int c = 0; c < 4; c++) begin
      w_cs[c] = in_code[20+c] ^ in_code[c] ^ in_code[4+c] ^ in_code[8+c] ^ in_code[12+c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_rs    <= '0;
      r_s1_cs    <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_data  <= in_code[15:0];
      r_s1_rs    <= w_rs;
      r_s1_cs    <= w_cs;
    end
  end

  // A lone row hit plus a lone column hit pinpoints the flipped data bit.
  always_comb begin
    w_rs_pop = '0;
    w_cs_pop = '0;
    w_row    = '0;
    w_col    = '0;
    for (int i = 0; i < 4; i++) begin
      w_rs_pop = w_rs_pop + {2'b00, r_s1_rs[i]};
      w_cs_pop = w_cs_pop + {2'b00, r_s1_cs[i]};
      if (r_s1_rs[i]) w_row = 2'(i);
      if (r_s1_cs[i]) w_col = 2'(i);
    end
    w_dec_data   = r_s1_data;
    w_dec_status = c_ST_UNCORR;
    if (r_s1_rs == 4'd0 && r_s1_cs == 4'd0) begin
      w_dec_status = c_ST_CLEAN;
    end else if (w_rs_pop == 3'd1 && w_cs_pop == 3'd1) begin
      w_dec_data[{w_row, w_col}] = ~r_s1_data[{w_row, w_col}];
      w_dec_status = c_ST_CORR;
    end else if (w_rs_pop + w_cs_pop == 3'd1) begin
      w_dec_status = c_ST_PARITY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_status <= c_ST_CLEAN;
    end else if (w_en) begin
      out_valid  <= r_s1_valid;
      out_data   <= w_dec_data;
      out_status <= w_dec_status;
    end
  end

`ifdef VH_DEC_STATS_EN
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (stat_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if ((out_status == c_ST_CORR || out_status == c_ST_PARITY) && r_corr_cnt != '1)
        r_corr_cnt <= r_corr_cnt + c_CNT_ONE;
      if (out_status == c_ST_UNCORR && r_uncorr_cnt != '1)
        r_uncorr_cnt <= r_uncorr_cnt + c_CNT_ONE;
    end
  end

  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr;
  assign corr_cnt          = '0;
  assign uncorr_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vh_parity_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_vh_parity_decoder
// Brief   : Scoreboard bench for vh_parity_decoder (CNT_W=4; counter checks
//           follow VH_DEC_STATS_EN).
// Rev     : 1.0  initial release
// ============================================================================
module tb_vh_parity_decoder;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [23:0]      in_code;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      out_data;
  logic [1:0]       out_status;
  logic             out_valid;
  logic             out_ready;
  logic             stat_clr;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  vh_parity_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_status(out_status),
    .out_valid(out_valid), .out_ready(out_ready), .stat_clr(stat_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  status;
  } exp_t;

  exp_t             sb[$];
  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] m_corr   = '0;
  logic [CNT_W-1:0] m_unc    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counters first (reflect transfers up to the previous edge), then
  // pop and compare any word transferring at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_corr = '0;
      m_unc  = '0;
    end else begin
      check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
      check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_unc));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got data 0x%0h with no word outstanding", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_status", 32'(out_status), 32'(e.status));
`ifdef VH_DEC_STATS_EN
          if (!stat_clr) begin
            if ((e.status == 2'b01 || e.status == 2'b10) && m_corr != '1) m_corr = m_corr + 1'b1;
            if (e.status == 2'b11 && m_unc != '1) m_unc = m_unc + 1'b1;
          end
`endif
        end
      end
`ifdef VH_DEC_STATS_EN
      if (stat_clr) begin
        m_corr = '0;
        m_unc  = '0;
      end
`endif
    end
  end

  task automatic send(input logic [23:0] code, input logic [15:0] d, input logic [1:0] s);
    int   n = 0;
    exp_t e;
    in_code  = code;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for code 0x%06h", code);
    end else begin
      e.data   = d;
      e.status = s;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d words outstanding expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    logic [15:0] held;
    logic [31:0] sat_exp;

    rst_n     = 1'b0;
    in_code   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stat_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_status", 32'(out_status), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    check("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: clean word appears exactly two edges after its transfer.
    send(24'h110001, 16'h0001, 2'b00);
    check("lat_valid_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'h0001);
    drain();

    // Directed single words.
    send(24'h000020, 16'h0000, 2'b01);  // d5 flipped
    send(24'h100001, 16'h0001, 2'b10);  // r0 flipped
    send(24'h000021, 16'h0021, 2'b11);  // double error
    send(24'h00FFFF, 16'hFFFF, 2'b00);  // all ones, clean
    send(24'h888000, 16'h8000, 2'b00);  // d15 with r3/c3 set
    send(24'h880000, 16'h8000, 2'b01);  // d15 flipped
    send(24'h088000, 16'h8000, 2'b10);  // c3 flipped
    send(24'h000007, 16'h0007, 2'b11);  // triple error in one row
    send(24'h000003, 16'h0003, 2'b11);  // rs=0, two column hits
    drain();

    // Back-to-back stream with a 3-cycle stall after the first output.
    fork
      begin
        send(24'h110001, 16'h0001, 2'b00);
        send(24'h000020, 16'h0000, 2'b01);
        send(24'h888000, 16'h8000, 2'b00);
        send(24'h00FFFF, 16'hFFFF, 2'b00);
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("bp_first_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        held = out_data;
        check("bp_held_word", 32'(held), 32'h0000);
        repeat (3) begin
          @(negedge clk);
          check("bp_stall_valid", 32'(out_valid), 32'd1);
          check("bp_stall_data", 32'(out_data), 32'(held));
          check("bp_stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two words in flight.
    send(24'h000020, 16'h0000, 2'b01);
    send(24'h000021, 16'h0021, 2'b11);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_flight_valid", 32'(out_valid), 32'd0);
    check("rst_flight_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_rel_in_ready", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("rst_rel_no_output", 32'(out_valid), 32'd0);

    // Saturation: 16 corrected words into a 4-bit counter.
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    for (int i = 0; i < 16; i++) send(24'h000020, 16'h0000, 2'b01);
    drain();
`ifdef VH_DEC_STATS_EN
    sat_exp = 32'd15;
`else
    sat_exp = 32'd0;
`endif
    check("corr_saturated", 32'(corr_cnt), sat_exp);

    // stat_clr coincident with a delivery wins.
    out_ready = 1'b0;
    send(24'h000021, 16'h0021, 2'b11);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("clr_word_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    stat_clr  = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    check("clr_corr_cnt", 32'(corr_cnt), 32'd0);
    check("clr_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
